// File: rtl/io_map_pkg.sv
// IO map shared by the MMIO responder and its UART transmit serializer:
// region select nibble, register offsets, STATUS bit positions and the
// serializer state encoding.
package io_map_pkg;

  localparam logic [3:0] IO_REGION     = 4'h8;

  localparam logic [7:0] OFF_STATUS    = 8'h00;
  localparam logic [7:0] OFF_RX_DATA   = 8'h04;
  localparam logic [7:0] OFF_TX_DATA   = 8'h08;
  localparam logic [7:0] OFF_CYCLE_CNT = 8'h10;
  localparam logic [7:0] OFF_INST_CNT  = 8'h14;
  localparam logic [7:0] OFF_CNT_RESET = 8'h18;

  localparam int STAT_TX_READY    = 0;
  localparam int STAT_RX_VALID    = 1;
  localparam int STAT_TX_OVERFLOW = 2;
  localparam int STAT_RX_OVERRUN  = 3;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // Assemble the STATUS word from its individual flags.
  function automatic logic [31:0] pack_status(input logic tx_ready,
                                              input logic rx_valid,
                                              input logic tx_overflow,
                                              input logic rx_overrun);
    logic [31:0] s;
    s                   = '0;
    s[STAT_TX_READY]    = tx_ready;
    s[STAT_RX_VALID]    = rx_valid;
    s[STAT_TX_OVERFLOW] = tx_overflow;
    s[STAT_RX_OVERRUN]  = rx_overrun;
    return s;
  endfunction

endpackage

// File: rtl/mmio_io_responder_if.sv
// Core data-memory port as seen by the IO responder. The core drives the
// address/enables/store data; the responder returns registered read data.
interface mmio_io_responder_if;
  logic [31:0] io_addr;
  logic [3:0]  io_we;
  logic        io_re;
  logic [31:0] io_din;
  logic [31:0] io_dout;

  modport master (output io_addr, output io_we, output io_re, output io_din,
                  input  io_dout);
  modport slave  (input  io_addr, input  io_we, input  io_re, input  io_din,
                  output io_dout);
endinterface

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter, LSB first. Takes one byte per data_valid/data_ready
// handshake; each of START, the 8 DATA bits and STOP lasts BIT_PERIOD
// cycles. A waiting byte is accepted in the last STOP cycle so consecutive
// frames have no idle gap.
module uart_tx_serializer
  import io_map_pkg::*;
#(
  parameter int BIT_PERIOD = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       serial_out
);

  localparam int CNT_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(BIT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  tx_state_e        state_q;
  logic [CNT_W-1:0] baud_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             serial_q;

  logic bit_end;
  logic load;
  logic advance;

  assign bit_end    = (baud_q == '0);
  assign data_ready = (state_q == TX_IDLE) || ((state_q == TX_STOP) && bit_end);
  assign load       = data_valid && data_ready;
  assign advance    = bit_end && ((state_q == TX_START) ||
                                  ((state_q == TX_DATA) && (bit_q != 3'd7)));
  assign serial_out = serial_q;

  // Frame sequencing: state, baud countdown (reloaded on every state or bit
  // change), bit index and the registered line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= TX_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      serial_q <= 1'b1;
    end else begin
      case (state_q)
        TX_IDLE: begin
          serial_q <= 1'b1;
          if (data_valid) begin
            state_q  <= TX_START;
            baud_q   <= RELOAD;
            serial_q <= 1'b0;
          end
        end
        TX_START: begin
          if (bit_end) begin
            state_q  <= TX_DATA;
            baud_q   <= RELOAD;
            bit_q    <= 3'd0;
            serial_q <= shift_q[0];
          end else begin
            baud_q <= baud_q - CNT_ONE;
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            baud_q <= RELOAD;
            if (bit_q == 3'd7) begin
              state_q  <= TX_STOP;
              serial_q <= 1'b1;
            end else begin
              bit_q    <= bit_q + 3'd1;
              serial_q <= shift_q[0];
            end
          end else begin
            baud_q <= baud_q - CNT_ONE;
          end
        end
        TX_STOP: begin
          if (bit_end) begin
            if (data_valid) begin
              state_q  <= TX_START;
              baud_q   <= RELOAD;
              serial_q <= 1'b0;
            end else begin
              state_q  <= TX_IDLE;
              serial_q <= 1'b1;
            end
          end else begin
            baud_q <= baud_q - CNT_ONE;
          end
        end
        default: begin
          state_q  <= TX_IDLE;
          serial_q <= 1'b1;
        end
      endcase
    end
  end

  // Byte shift register: loaded on acceptance, shifted right as each bit
  // is put on the line so bit 0 always holds the next bit to send.
  always_ff @(posedge clk) begin
    if (load) begin
      shift_q <= data_in;
    end else if (advance) begin
      shift_q <= {1'b0, shift_q[7:1]};
    end
  end

endmodule

// File: rtl/mmio_io_responder.sv
// Memory-mapped IO responder on the core's data-memory port, in parallel
// with data BRAM. Provides a FIFO-buffered UART transmitter, a latched UART
// receive byte with overrun detection, and (with IO_COUNTERS_EN defined)
// cycle / retired-instruction counters. Read data is registered, giving the
// same one-cycle latency as block RAM.
// Build option: define IO_COUNTERS_EN to implement CYCLE_CNT, INST_CNT and
// CNT_RESET; otherwise those offsets read as zero and writes are ignored.
module mmio_io_responder
  import io_map_pkg::*;
#(
  parameter int CLOCK_FREQ    = 50000000,
  parameter int BAUD_RATE     = 115200,
  parameter int TX_FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  mmio_io_responder_if.slave  io,
  input  logic [7:0]          rx_byte,
  input  logic                rx_byte_valid,
  input  logic                inst_retired,
  output logic                serial_out
);

  localparam int BIT_PERIOD = CLOCK_FREQ / BAUD_RATE;
  localparam int AW         = $clog2(TX_FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Address decode
  logic       sel;
  logic [7:0] off;
  logic       wr;
  logic       rd;
  logic       wr_status;
  logic       wr_tx;
  logic       rd_rx;

  assign sel       = (io.io_addr[31:28] == IO_REGION);
  assign off       = io.io_addr[7:0];
  assign wr        = sel && (|io.io_we);
  assign rd        = sel && io.io_re;
  assign wr_status = wr && (off == OFF_STATUS);
  assign wr_tx     = wr && (off == OFF_TX_DATA);
  assign rd_rx     = rd && (off == OFF_RX_DATA);

  // Transmit FIFO
  logic [7:0]  fifo_mem_q [TX_FIFO_DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        pop;
  logic        ser_ready;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push       = wr_tx && !fifo_full;
  assign pop        = ser_ready && !fifo_empty;

  // FIFO pointers; the extra top bit distinguishes full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // FIFO storage; a write while full is dropped.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q[AW-1:0]] <= io.io_din[7:0];
    end
  end

  uart_tx_serializer #(
    .BIT_PERIOD (BIT_PERIOD)
  ) u_tx (
    .clk        (clk),
    .rst        (rst),
    .data_in    (fifo_mem_q[rd_ptr_q[AW-1:0]]),
    .data_valid (!fifo_empty),
    .data_ready (ser_ready),
    .serial_out (serial_out)
  );

  // Status flags
  logic       tx_overflow_q;
  logic       rx_valid_q;
  logic       rx_overrun_q;
  logic [7:0] rx_byte_q;

  // Sticky error flags: a STATUS write clears them, but an error event in
  // the same cycle still sets them so it is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_overflow_q <= 1'b0;
      rx_overrun_q  <= 1'b0;
    end else begin
      if (wr_status) begin
        tx_overflow_q <= 1'b0;
        rx_overrun_q  <= 1'b0;
      end
      if (wr_tx && fifo_full) begin
        tx_overflow_q <= 1'b1;
      end
      if (rx_byte_valid && rx_valid_q && !rd_rx) begin
        rx_overrun_q <= 1'b1;
      end
    end
  end

  // Receive-valid: a new byte wins over a concurrent RX_DATA read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid_q <= 1'b0;
    end else if (rx_byte_valid) begin
      rx_valid_q <= 1'b1;
    end else if (rd_rx) begin
      rx_valid_q <= 1'b0;
    end
  end

  // Receive byte latch; always holds the most recent byte.
  always_ff @(posedge clk) begin
    if (rx_byte_valid) begin
      rx_byte_q <= rx_byte;
    end
  end

`ifdef IO_COUNTERS_EN
  logic        wr_cnt_rst;
  logic [31:0] cycle_cnt_q;
  logic [31:0] inst_cnt_q;

  assign wr_cnt_rst = wr && (off == OFF_CNT_RESET);

  // Free-running counters; a CNT_RESET write overrides that cycle's count.
  always_ff @(posedge clk) begin
    if (rst || wr_cnt_rst) begin
      cycle_cnt_q <= '0;
      inst_cnt_q  <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (inst_retired) inst_cnt_q <= inst_cnt_q + 32'd1;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{io.io_addr[27:8], io.io_din[31:8]};
`else
  logic unused_bits;
  assign unused_bits = ^{io.io_addr[27:8], io.io_din[31:8], inst_retired};
`endif

  // Read data mux; anything not a mapped IO register reads as zero.
  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (off)
        OFF_STATUS:    rdata = pack_status(!fifo_full, rx_valid_q,
                                           tx_overflow_q, rx_overrun_q);
        OFF_RX_DATA:   rdata = {24'h0, rx_byte_q};
`ifdef IO_COUNTERS_EN
        OFF_CYCLE_CNT: rdata = cycle_cnt_q;
        OFF_INST_CNT:  rdata = inst_cnt_q;
`endif
        default:       rdata = '0;
      endcase
    end
  end

  logic [31:0] io_dout_q;

  // Registered read port: captured on every read, held between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      io_dout_q <= '0;
    end else if (io.io_re) begin
      io_dout_q <= rdata;
    end
  end

  assign io.io_dout = io_dout_q;

endmodule
